// File: rtl/lstm_weight_bank_if.sv
// rtl/lstm_weight_bank_if.sv - write port, burst control and read stream of the LSTM weight bank
interface lstm_weight_bank_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                        wr_en;
  logic [BANK_W-1:0]           wr_bank;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        start;
  logic [ADDR_W-1:0]           base_addr;
  logic [ADDR_W:0]             length;
  logic                        busy;
  logic                        done;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [NUM_BANKS*DATA_W-1:0] rd_data;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data, start, base_addr, length, rd_ready,
    input  busy, done, rd_valid, rd_data
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data, start, base_addr, length, rd_ready,
    output busy, done, rd_valid, rd_data
  );
endinterface

// File: rtl/lstm_weight_bank.sv
// rtl/lstm_weight_bank.sv - multi-bank LSTM weight store with burst read engine and skid-buffered stream
module lstm_weight_bank #(
  parameter int    DATA_W         = 16,
  parameter int    DEPTH          = 400,
  parameter int    ADDR_W         = 9,
  parameter int    NUM_BANKS      = 4,
  parameter int    OUT_REG        = 1,
  parameter string COLLISION_MODE = "READ_FIRST"
) (
  input logic               clk,
  input logic               rst_n,
  lstm_weight_bank_if.slave bus
);
  localparam int LAT    = (OUT_REG != 0) ? 2 : 1;
  localparam int SKID   = LAT + 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BEAT_W = NUM_BANKS * DATA_W;
  localparam bit WRITE_FIRST = (COLLISION_MODE == "WRITE_FIRST");
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [1:0]        count_q, wptr_q, rptr_q;
  logic              done_q;
  logic              in_flight, issue, push, pop, last_hs;
  logic [BEAT_W-1:0] rd_word, push_data;
  logic [BEAT_W-1:0] skid [SKID];

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(SKID - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check: never issue more reads than the skid buffer can absorb if the sink stalls.
  assign issue   = (state_q == RUN) && ((3'(count_q) + 3'(in_flight)) < 3'(SKID));
  assign pop     = bus.rd_valid && bus.rd_ready;
  assign last_hs = (state_q == DRAIN) && !in_flight && (count_q == 2'd1) && pop;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;

    assign we = bus.wr_en && (bus.wr_bank == BANK_W'(b)) && ({1'b0, bus.wr_addr} < DEPTH_W);

    always_ff @(posedge clk) begin
      if (we) mem[bus.wr_addr] <= bus.wr_data;
    end

    assign rd_word[b*DATA_W +: DATA_W] =
      (WRITE_FIRST && we && (bus.wr_addr == addr_q)) ? bus.wr_data : mem[addr_q];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [BEAT_W-1:0] ram_q;
    logic              v_q;

    always_ff @(posedge clk) begin
      if (issue) ram_q <= rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else        v_q <= issue;
    end

    assign in_flight = v_q;
    assign push      = v_q;
    assign push_data = ram_q;
  end else begin : g_noreg
    assign in_flight = 1'b0;
    assign push      = issue;
    assign push_data = rd_word;
  end

  always_ff @(posedge clk) begin
    if (push) skid[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 2'd0;
    end else begin
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && (bus.length != '0)) state_d = RUN;
      RUN:     if (issue && (remain_q == (ADDR_W+1)'(1))) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= ((state_q == IDLE) && bus.start && (bus.length == '0)) || last_hs;
      if ((state_q == IDLE) && bus.start) begin
        addr_q   <= bus.base_addr;
        remain_q <= bus.length;
      end else if (issue) begin
        // Wrap at the bank depth, not at the power-of-two address range.
        addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.rd_valid = (count_q != 2'd0);
  assign bus.rd_data  = bus.rd_valid ? skid[rptr_q] : '0;
endmodule

// File: tb/tb_lstm_weight_bank.sv
// tb/tb_lstm_weight_bank.sv - directed bench for lstm_weight_bank with an array/queue reference model
module tb_lstm_weight_bank;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 400;
  localparam int ADDR_W = 9;
  localparam int NB     = 4;
  localparam int BW     = 2;
  localparam int BEAT_W = NB * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lstm_weight_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB)) b1 ();
  lstm_weight_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB)) b2 ();

  lstm_weight_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_BANKS(NB),
    .OUT_REG(1), .COLLISION_MODE("READ_FIRST")
  ) dut (.clk(clk), .rst_n(rst_n), .bus(b1));

  lstm_weight_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_BANKS(NB),
    .OUT_REG(0), .COLLISION_MODE("WRITE_FIRST")
  ) dut_wf (.clk(clk), .rst_n(rst_n), .bus(b2));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_start = 0;
  int hs_count = 0;
  int hs_base = 0;
  int first_valid_cyc = -1;
  int done_cyc = -1;
  int done_pulses = 0;
  bit ready_rand = 1'b0;
  bit prev_stall = 1'b0;
  logic [BEAT_W-1:0] prev_data;
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] got_q[$];
  logic [DATA_W-1:0] mm [NB][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_at(input int a);
    logic [BEAT_W-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DATA_W +: DATA_W] = mm[b][a];
    return r;
  endfunction

  // Scoreboard: every handshake is compared with the next expected beat; stalls must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(b1.rd_valid), 64'd1);
        check("stall_hold_data", b1.rd_data, prev_data);
      end
      if (b1.rd_valid) check("valid_inside_burst", 64'(b1.busy), 64'd1);
      if (b1.done) begin
        done_cyc = cyc;
        done_pulses++;
      end
      if (b1.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (b1.rd_valid && b1.rd_ready) begin
        hs_count++;
        got_q.push_back(b1.rd_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h, no beat expected (cycle %0d)", b1.rd_data, cyc);
        end else begin
          check("beat", b1.rd_data, exp_q.pop_front());
        end
      end
      prev_stall = b1.rd_valid && !b1.rd_ready;
      prev_data  = b1.rd_data;
    end
  end

  initial begin
    b1.rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      b1.rd_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int bk, input int a, input logic [DATA_W-1:0] d);
    b1.wr_en = 1'b1; b1.wr_bank = BW'(bk); b1.wr_addr = ADDR_W'(a); b1.wr_data = d;
    tick();
    b1.wr_en = 1'b0;
    mm[bk][a] = d;
  endtask

  task automatic burst(input int base, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back(beat_at((base + k) % DEPTH));
    got_q.delete();
    first_valid_cyc = -1;
    hs_base = hs_count;
    t_start = cyc;
    b1.start = 1'b1; b1.base_addr = ADDR_W'(base); b1.length = (ADDR_W+1)'(len);
    tick();
    b1.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    int d0 = done_pulses;
    while (done_pulses == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_pulses == d0) begin
      fails++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
    tick();
  endtask

  initial begin
    logic [BEAT_W-1:0] g;
    int d;
    b1.wr_en = 0; b1.wr_bank = 0; b1.wr_addr = 0; b1.wr_data = 0;
    b1.start = 0; b1.base_addr = 0; b1.length = 0;
    b2.wr_en = 0; b2.wr_bank = 0; b2.wr_addr = 0; b2.wr_data = 0;
    b2.start = 0; b2.base_addr = 0; b2.length = 0; b2.rd_ready = 1'b1;

    repeat (3) tick();
    check("reset_busy", 64'(b1.busy), 64'd0);
    check("reset_done", 64'(b1.done), 64'd0);
    check("reset_valid", 64'(b1.rd_valid), 64'd0);
    check("reset_data", b1.rd_data, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) wr(b, a, 16'(b * 100 + a));

    // Full-depth burst at one beat per cycle.
    burst(0, 400);
    check("busy_rise", 64'(b1.busy), 64'd1);
    wait_done("full_done", 1000);
    check("full_first_valid", 64'(first_valid_cyc), 64'(t_start + 3));
    check("full_done_cycle", 64'(done_cyc), 64'(t_start + 403));
    check("full_beats", 64'(hs_count - hs_base), 64'd400);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);
    g = got_q[0];
    check("full_beat0", g, {16'd300, 16'd200, 16'd100, 16'd0});
    g = got_q[399];
    check("full_beat399", g, {16'd699, 16'd599, 16'd499, 16'd399});

    // Address wrap at DEPTH.
    burst(398, 5);
    wait_done("wrap_done", 100);
    g = got_q[1];
    check("wrap_beat1", 64'(g[15:0]), 64'd399);
    g = got_q[2];
    check("wrap_beat2", 64'(g[15:0]), 64'd0);
    g = got_q[4];
    check("wrap_beat4_bank3", 64'(g[63:48]), 64'd302);

    // Random backpressure.
    ready_rand = 1'b1;
    burst(50, 64);
    wait_done("bp_done", 2000);
    ready_rand = 1'b0;
    check("bp_beats", 64'(hs_count - hs_base), 64'd64);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length burst.
    burst(7, 0);
    check("zero_done_pulse", 64'(b1.done), 64'd1);
    check("zero_busy", 64'(b1.busy), 64'd0);
    tick();
    check("zero_done_single", 64'(b1.done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("zero_no_valid", 64'(b1.rd_valid), 64'd0);
      tick();
    end

    // Start while busy is ignored.
    burst(20, 8);
    tick();
    b1.start = 1'b1; b1.base_addr = ADDR_W'(100); b1.length = (ADDR_W+1)'(5);
    tick();
    b1.start = 1'b0;
    wait_done("busy_start_done", 100);
    d = done_pulses;
    repeat (10) tick();
    check("busy_start_beats", 64'(hs_count - hs_base), 64'd8);
    check("busy_start_no_done", 64'(done_pulses), 64'(d));
    check("busy_start_queue", 64'(exp_q.size()), 64'd0);

    // READ_FIRST collision on bank 2, address 10.
    wr(2, 10, 16'h0AAA);
    burst(10, 1);
    b1.wr_en = 1'b1; b1.wr_bank = 2'd2; b1.wr_addr = ADDR_W'(10); b1.wr_data = 16'h0BBB;
    tick();
    b1.wr_en = 1'b0;
    mm[2][10] = 16'h0BBB;
    wait_done("rf_done", 100);
    g = got_q[0];
    check("rf_collision", g, {16'd310, 16'h0AAA, 16'd110, 16'd10});
    burst(10, 1);
    wait_done("rf_after_done", 100);
    g = got_q[0];
    check("rf_after_write", 64'(g[47:32]), 64'h0BBB);

    // WRITE_FIRST collision on the LAT=1 instance.
    for (int b = 0; b < NB; b++) begin
      b2.wr_en = 1'b1; b2.wr_bank = BW'(b); b2.wr_addr = ADDR_W'(10);
      b2.wr_data = (b == 2) ? 16'h0AAA : 16'h0A00 + 16'(b);
      tick();
    end
    b2.wr_en = 1'b0;
    b2.start = 1'b1; b2.base_addr = ADDR_W'(10); b2.length = (ADDR_W+1)'(1);
    tick();
    b2.start = 1'b0;
    check("wf_no_valid_yet", 64'(b2.rd_valid), 64'd0);
    b2.wr_en = 1'b1; b2.wr_bank = 2'd2; b2.wr_addr = ADDR_W'(10); b2.wr_data = 16'h0BBB;
    tick();
    b2.wr_en = 1'b0;
    check("wf_valid", 64'(b2.rd_valid), 64'd1);
    check("wf_collision", b2.rd_data, {16'h0A03, 16'h0BBB, 16'h0A01, 16'h0A00});
    tick();
    check("wf_done", 64'(b2.done), 64'd1);
    check("wf_busy_drop", 64'(b2.busy), 64'd0);

    // Asynchronous reset mid-burst after 7 beats.
    burst(0, 20);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (hs_count - hs_base >= 7) break;
    end
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(b1.rd_valid), 64'd0);
    check("rst_busy", 64'(b1.busy), 64'd0);
    check("rst_done", 64'(b1.done), 64'd0);
    check("rst_beats", 64'(hs_count - hs_base), 64'd7);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    burst(0, 4);
    wait_done("post_rst_done", 100);
    check("post_rst_beats", 64'(hs_count - hs_base), 64'd4);
    g = got_q[3];
    check("post_rst_beat3", g, {16'd303, 16'd203, 16'd103, 16'd3});
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lstm_weight_bank.md
Name: lstm_weight_bank

Overview:
- Multi-bank on-chip weight store for the LSTM datapath: NUM_BANKS parallel block-RAM banks (one per gate by default: i, f, g, o).
- Replaces single-bank, free-running-read weight memories with three additions: a burst read engine, a valid/ready output stream and selectable write/read collision behaviour.
- Sits between the weight loader (write side) and the gate MAC array (stream side).
- Per accepted beat, all banks read the same address and present NUM_BANKS words side by side.

Parameters:
- DATA_W, 16, width of one weight word.
- DEPTH, 400, words per bank.
- ADDR_W, 9, address width; must satisfy 2^ADDR_W >= DEPTH.
- NUM_BANKS, 4, number of parallel banks.
- OUT_REG, 1, 1 adds an output pipeline register to the RAM read (read latency LAT=2); 0 gives LAT=1.
- COLLISION_MODE, "READ_FIRST", "READ_FIRST" or "WRITE_FIRST"; applies when a read and a write hit the same bank and address in the same cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_bank  in  clog2(NUM_BANKS)  target bank for the write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  single-cycle burst request; honoured only in IDLE.
- base_addr  in  ADDR_W  first address of the burst; sampled with start.
- length  in  ADDR_W+1  beats in the burst, 0..DEPTH; sampled with start.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- rd_valid  out  1  stream beat valid.
- rd_ready  in  1  downstream accepts the beat.
- rd_data  out  NUM_BANKS*DATA_W  bank b occupies bits [b*DATA_W +: DATA_W].

Behaviour:
- Reset is asynchronous and active-low, and must be honoured at any time. On reset:
  - FSM returns to IDLE.
  - busy, done and rd_valid go to 0; rd_data goes to 0.
  - Skid buffer is emptied; in-flight reads are discarded; counters are cleared.
  - Memory contents are preserved; after configuration all banks power up as zeros.
- Writes:
  - Independent of the FSM and accepted in every state.
  - Take effect at the clock edge on which wr_en is sampled high.
  - A write is ignored if wr_bank >= NUM_BANKS or wr_addr >= DEPTH.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start with length>0 latches base_addr and length, then moves to RUN; busy rises the next cycle.
  - start with length=0: no beats are issued; done pulses the next cycle; the FSM stays in IDLE.
  - start outside IDLE is ignored.
- RUN:
  - Issues one read address per cycle while in_flight + buffer_occupancy < LAT+1.
  - The skid buffer depth is LAT+1, so rd_ready held high sustains one beat per cycle.
  - Address sequence is base_addr, base_addr+1, ...; it wraps from DEPTH-1 to 0 (modulo DEPTH, not 2^ADDR_W).
  - After the length-th address is issued, the FSM moves to DRAIN.
- DRAIN:
  - Waits until the last beat handshakes (rd_valid && rd_ready).
  - Then pulses done for one cycle, drops busy in that same cycle and returns to IDLE.
  - A start arriving in the done cycle is accepted.
- Timing with start at cycle T and rd_ready held high:
  - First address is issued at T+1.
  - First rd_valid is at T+1+LAT.
  - The last beat is at T+LAT+length, and done is at T+LAT+length+1.
- Stream rules:
  - Beats leave in issue order.
  - Once rd_valid is high, rd_valid and rd_data hold stable until the handshake.
  - No beat is dropped or duplicated under any rd_ready pattern.
  - rd_valid never asserts outside a burst.
- Collision (same bank, same address, same cycle as a read issue):
  - READ_FIRST: that bank returns the old word.
  - WRITE_FIRST: that bank returns wr_data.
  - Other banks are unaffected.

Test Plan:
- Write bank b, address a with value 16'h(b*100+a) for all 4x400 locations. Then start base=0, length=400, rd_ready=1. Required: 400 consecutive beats, beat k = {o,g,f,i} words k; first rd_valid at T+3 (OUT_REG=1); done at T+403.
- Start base=398, length=5. Required: address order 398, 399, 0, 1, 2, with matching data.
- Backpressure: rd_ready toggles with a pseudo-random 50% duty over a 64-beat burst. Required: all 64 beats in order, none lost or repeated; rd_data stable while rd_valid && !rd_ready.
- Collision at address 10 of bank 2 with old=16'h0AAA, new=16'h0BBB. Required: beat reads 0AAA under READ_FIRST and 0BBB under WRITE_FIRST; banks 0, 1 and 3 unchanged.
- Edge starts:
  - length=0 -> done pulse one cycle after start, no rd_valid.
  - A second start while busy -> ignored; beat count is unchanged.
- Assert rst_n low mid-burst after 7 beats. Required: rd_valid, busy and done go to 0 immediately. After release, a new burst base=0, length=4 returns the previously written data.
